// File: rtl/anspwm_combine_pwm_if.sv
// Sample handshake bundle feeding the ANS-PWM combine stage: stage-1 quant plus
// the two sign-magnitude correction terms, paced by a valid/ready pair.
interface anspwm_combine_pwm_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] q1;
  logic [W-1:0] c2;
  logic         c2s;
  logic [W-1:0] c3;
  logic         c3s;

  modport master (output in_valid, q1, c2, c2s, c3, c3s, input in_ready);
  modport slave  (input in_valid, q1, c2, c2s, c3, c3s, output in_ready);
endinterface

// File: rtl/anspwm_combine_pwm.sv
// ANS-PWM final stage: signed sum of q1 and the c2/c3 corrections, clamp to the
// PWM range, load as duty at the next frame boundary. Optional macro: SAT_COUNT_EN.
module anspwm_combine_pwm #(
  parameter int W        = 16,
  parameter int PWM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  anspwm_combine_pwm_if.slave in_if,
  output logic                pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic                frame_start,
  output logic                sat,
`ifdef SAT_COUNT_EN
  output logic [15:0]         sat_cnt,
`endif
  output logic [1:0]          dbg_state
);

  // Handshake: a sample transfers on a clk edge where in_valid && in_ready;
  // in_ready is registered and stays low from accept until the duty loads.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    CLAMP = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // Three extra bits so q1 + c2 + c3 at full scale cannot wrap.
  localparam int SW = W + 3;
  localparam logic [PWM_BITS-1:0] DMAX = '1;
  localparam logic signed [SW-1:0] DMAX_S = SW'(DMAX);

  state_t                state;
  logic [PWM_BITS-1:0]   cnt;
  logic [PWM_BITS-1:0]   cnt_n;
  logic [PWM_BITS-1:0]   duty_n;
  logic [PWM_BITS-1:0]   pend;
  logic                  psat;
  logic                  ready_r;
  logic                  load;
  logic [W-1:0]          q1_r, c2_r, c3_r;
  logic                  c2s_r, c3s_r;
  logic signed [SW-1:0]  s;
  logic signed [SW-1:0]  sum_c;
  logic signed [SW-1:0]  q1_e, c2_e, c3_e;

  assign in_if.in_ready = ready_r;
  assign dbg_state      = state;

  assign cnt_n  = cnt + 1'b1;
  assign load   = (state == WAIT) && (cnt == DMAX);
  assign duty_n = load ? pend : duty;

  always_comb begin
    q1_e  = SW'(q1_r);
    c2_e  = c2s_r ? -SW'(c2_r) : SW'(c2_r);
    c3_e  = c3s_r ? -SW'(c3_r) : SW'(c3_r);
    sum_c = q1_e + c2_e + c3_e;
  end

  // pwm and frame_start are registered from next-cycle values so they line up
  // with the cnt/duty pair in force during the same clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      duty        <= '0;
      pwm         <= 1'b0;
      frame_start <= 1'b0;
      sat         <= 1'b0;
      ready_r     <= 1'b1;
      q1_r        <= '0;
      c2_r        <= '0;
      c3_r        <= '0;
      c2s_r       <= 1'b0;
      c3s_r       <= 1'b0;
      s           <= '0;
      pend        <= '0;
      psat        <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      frame_start <= (cnt == DMAX);
      pwm         <= (cnt_n < duty_n);
      case (state)
        IDLE: begin
          if (in_if.in_valid) begin
            q1_r    <= in_if.q1;
            c2_r    <= in_if.c2;
            c2s_r   <= in_if.c2s;
            c3_r    <= in_if.c3;
            c3s_r   <= in_if.c3s;
            ready_r <= 1'b0;
            state   <= SUM;
          end
        end
        SUM: begin
          s     <= sum_c;
          state <= CLAMP;
        end
        CLAMP: begin
          if (s < 0) begin
            pend <= '0;
            psat <= 1'b1;
          end else if (s > DMAX_S) begin
            pend <= DMAX;
            psat <= 1'b1;
          end else begin
            pend <= s[PWM_BITS-1:0];
            psat <= 1'b0;
          end
          state <= WAIT;
        end
        WAIT: begin
          if (load) begin
            duty    <= pend;
            sat     <= psat;
            ready_r <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAT_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (load && psat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_anspwm_combine_pwm.sv
// Self-checking bench for anspwm_combine_pwm at PWM_BITS=4 against an
// event-scheduling reference model (frame arithmetic on an edge counter).
module tb_anspwm_combine_pwm;
  localparam int W    = 16;
  localparam int PB   = 4;
  localparam int PER  = 1 << PB;
  localparam int DMAX = PER - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  anspwm_combine_pwm_if #(.W(W)) bus ();

  logic          pwm;
  logic          frame_start;
  logic          sat;
  logic [PB-1:0] duty;
  logic [1:0]    dbg_state;
`ifdef SAT_COUNT_EN
  logic [15:0]   sat_cnt;
`endif

  anspwm_combine_pwm #(.W(W), .PWM_BITS(PB)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (bus.slave),
    .pwm         (pwm),
    .duty        (duty),
    .frame_start (frame_start),
    .sat         (sat),
`ifdef SAT_COUNT_EN
    .sat_cnt     (sat_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edges = clk edges since reset, so cnt is edges % PER.
  int   edges = 0;
  int   m_duty = 0;
  int   m_pend = 0;
  int   m_load_edge = 0;
  int   m_satcnt = 0;
  int   m_accepts = 0;
  int   m_s;
  logic m_sat = 1'b0;
  logic m_psat = 1'b0;
  logic m_ready = 1'b1;
  logic m_busy = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edges = 0; m_duty = 0; m_sat = 1'b0; m_ready = 1'b1; m_busy = 1'b0;
      m_satcnt = 0; m_pend = 0; m_psat = 1'b0; m_load_edge = 0;
    end else begin
      if (m_busy && edges == m_load_edge) begin
        m_duty = m_pend; m_sat = m_psat; m_ready = 1'b1; m_busy = 1'b0;
        if (m_psat && m_satcnt < 65535) m_satcnt++;
      end else if (m_ready && bus.in_valid) begin
        m_s = int'(bus.q1) + (bus.c2s ? -int'(bus.c2) : int'(bus.c2))
                           + (bus.c3s ? -int'(bus.c3) : int'(bus.c3));
        m_psat = (m_s < 0) || (m_s > DMAX);
        m_pend = (m_s < 0) ? 0 : ((m_s > DMAX) ? DMAX : m_s);
        m_load_edge = edges + 3;
        while (m_load_edge % PER != DMAX) m_load_edge++;
        m_ready = 1'b0; m_busy = 1'b1; m_accepts++;
      end
      edges++;
    end
  end

  logic [7:0] exp_vec, obs_vec;
  assign exp_vec = {((edges % PER) < m_duty), ((edges % PER) == 0) && (edges > 0),
                    m_ready, m_sat, 4'(m_duty)};
  assign obs_vec = {pwm, frame_start, bus.in_ready, sat, duty};

  task automatic send(input int q, input int a, input bit as, input int b, input bit bs);
    int guard = 0;
    while (!m_ready && guard < 64) begin @(negedge clk); guard++; end
    if (!m_ready) begin errors++; $display("FAIL send_wait got ready=%b want 1", m_ready); end
    bus.q1 = W'(q); bus.c2 = W'(a); bus.c2s = as; bus.c3 = W'(b); bus.c3s = bs;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    int fs_seen = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_vec !== 8'h20) begin
      errors++; $display("FAIL reset_outputs got=%b want=%b", obs_vec, 8'h20);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state got=%0d want=0", dbg_state);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL idle_vec cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      if (frame_start === 1'b1) fs_seen++;
    end
    checks++;
    if (fs_seen != 2) begin
      errors++; $display("FAIL idle_frame_starts got=%0d want=2", fs_seen);
    end
  endtask

  task automatic test_sum_clamp(input int q, input int a, input bit as, input int b,
                                input bit bs, input int exp_duty, input bit exp_sat);
    int highs = 0;
    send(q, a, as, b, bs);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL sum_vec q1=%0d cyc=%0d got=%b want=%b", q, i, obs_vec, exp_vec);
      end
      if (i >= 24 && pwm === 1'b1) highs++;
    end
    checks++;
    if (duty !== PB'(exp_duty) || sat !== exp_sat) begin
      errors++; $display("FAIL sum_final q1=%0d got duty=%0d sat=%b want duty=%0d sat=%b",
                         q, duty, sat, exp_duty, exp_sat);
    end
    checks++;
    if (highs != exp_duty) begin
      errors++; $display("FAIL pwm_high_clks q1=%0d got=%0d want=%0d", q, highs, exp_duty);
    end
  endtask

  task automatic test_back_to_back;
    logic [PB-1:0] exp_q[$];
    logic [PB-1:0] prev;
    logic [PB-1:0] e;
    int base, held4, guard;
    guard = 0;
    while (!m_ready && guard < 64) begin @(negedge clk); guard++; end
    exp_q = '{4'd4, 4'd9};
    prev = duty; base = m_accepts; held4 = 0;
    bus.q1 = 16'd4; bus.c2 = '0; bus.c2s = 1'b0; bus.c3 = '0; bus.c3s = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL b2b_vec cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      if (m_accepts == base + 1 && bus.q1 == 16'd4) bus.q1 = 16'd9;
      if (m_accepts == base + 2) bus.in_valid = 1'b0;
      if (duty !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_load got=%0d want none", duty);
        end else begin
          e = exp_q.pop_front();
          if (duty !== e) begin
            errors++; $display("FAIL b2b_load_order got=%0d want=%0d", duty, e);
          end
        end
        prev = duty;
      end
      if (duty === 4'd4) held4++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_missing_loads got=%0d left want=0", exp_q.size());
    end
    checks++;
    if (held4 != PER) begin
      errors++; $display("FAIL b2b_duty4_clks got=%0d want=%0d", held4, PER);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL rand_vec cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      bus.q1  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 65535)) : W'($urandom_range(0, 30));
      bus.c2  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 65535)) : W'($urandom_range(0, 20));
      bus.c3  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 65535)) : W'($urandom_range(0, 20));
      bus.c2s = 1'($urandom_range(0, 1));
      bus.c3s = 1'($urandom_range(0, 1));
      bus.in_valid = ($urandom_range(0, 2) == 0);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    send(7, 0, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (dbg_state !== 2'd3) begin
      errors++; $display("FAIL rst_wait_state got=%0d want=3", dbg_state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs_vec !== 8'h20) begin
      errors++; $display("FAIL rst_wait_outputs got=%b want=%b", obs_vec, 8'h20);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec || duty !== 4'd0) begin
        errors++; $display("FAIL rst_wait_vec cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.q1 = '0; bus.c2 = '0; bus.c2s = 1'b0; bus.c3 = '0; bus.c3s = 1'b0;
    test_reset();
    test_sum_clamp(5, 2, 1'b0, 1, 1'b1, 6, 1'b0);
    test_sum_clamp(3, 10, 1'b1, 0, 1'b0, 0, 1'b1);
    test_sum_clamp(20, 0, 1'b0, 0, 1'b0, 15, 1'b1);
`ifdef SAT_COUNT_EN
    checks++;
    if (sat_cnt !== 16'd2) begin
      errors++; $display("FAIL sat_cnt got=%0d want=2", sat_cnt);
    end
`endif
    test_back_to_back();
    test_random();
`ifdef SAT_COUNT_EN
    checks++;
    if (sat_cnt !== 16'(m_satcnt)) begin
      errors++; $display("FAIL sat_cnt_rand got=%0d want=%0d", sat_cnt, m_satcnt);
    end
`endif
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
